// File: rtl/tpu_pkg.sv
// Shared definitions for the tpu_mm2x2 matrix-vector engine.
// Build option: define SIGNED_MAC_EN to treat operands as two's-complement;
// leave it undefined for plain unsigned arithmetic.
package tpu_pkg;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int RES_W  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PROD_W = 2 * DATA_W;

  // APB register map (byte-free word addresses as seen on i_paddr)
  localparam logic [31:0] ADDR_W00  = 32'd0;
  localparam logic [31:0] ADDR_W01  = 32'd1;
  localparam logic [31:0] ADDR_W10  = 32'd2;
  localparam logic [31:0] ADDR_W11  = 32'd3;
  localparam logic [31:0] ADDR_RES  = 32'd0;
  localparam logic [31:0] ADDR_STAT = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Stage-1 pipeline payload: the four partial products, already reduced
  // to the result lane width.
  typedef struct packed {
    logic [RES_W-1:0] p00;  // in1 * W00
    logic [RES_W-1:0] p10;  // in2 * W10
    logic [RES_W-1:0] p01;  // in1 * W01
    logic [RES_W-1:0] p11;  // in2 * W11
  } prod_t;

  // Full-precision multiply, truncated to one result lane.
  function automatic logic [RES_W-1:0] mul_trunc(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] p;
`ifdef SIGNED_MAC_EN
    p = $unsigned($signed({{DATA_W{a[DATA_W-1]}}, a}) *
                  $signed({{DATA_W{b[DATA_W-1]}}, b}));
`else
    p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
    return RES_W'(p);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. Pushes to a full
// FIFO and pops from an empty one are ignored. DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next pointers and occupancy from the qualified push/pop strobes
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; stale words are never visible because
    // reads are qualified by empty, and leaving it unreset keeps it RAM-mappable.
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tpu_mm2x2.sv
// tpu_mm2x2: toy 2x2 weight-stationary matrix-vector engine.
// Weights are written over APB, vector elements are queued in two input
// FIFOs, and packed results {y2, y1} are drained from a result FIFO over APB.
// Two-stage pipeline: stage 1 registers the products, stage 2 adds them and
// pushes into the result FIFO (result visible two cycles after the pop).
// Build option: SIGNED_MAC_EN selects two's-complement operands.
module tpu_mm2x2
  import tpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              in1_en,
  input  logic              in2_en,
  input  logic              start,
  output logic              done,
  output logic [2:0]        o_full,
  output logic [2:0]        o_empty,
  input  logic [31:0]       i_paddr,
  input  logic              i_psel,
  input  logic              i_pwrite,
  input  logic [31:0]       i_pwdata,
  input  logic              i_penable,
  output logic [31:0]       o_prdata
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] w00_q, w01_q, w10_q, w11_q;

  logic [DATA_W-1:0] f0_rdata, f1_rdata, res_rdata, res_wdata;
  logic              f0_full, f0_empty, f1_full, f1_empty, res_full, res_empty;
  logic [CNT_W-1:0]  f0_cnt, f1_cnt, res_cnt;
  logic              unused_cnt;

  logic              pop_in;
  logic              res_pop;
  logic              apb_access;
  logic              wr_en;

  prod_t             prod_q, prod_d;
  logic              v1_q, v1_d;
  logic [RES_W-1:0]  y1, y2;

  // Input occupancies are not needed; only the result FIFO level gates issue.
  assign unused_cnt = ^{f0_cnt, f1_cnt};

  assign o_full  = {res_full, f1_full, f0_full};
  assign o_empty = {res_empty, f1_empty, f0_empty};

  // ---------------- APB decode ----------------
  assign apb_access = i_psel & i_penable;
  assign wr_en      = apb_access & i_pwrite & (state_q == S_IDLE);
  assign res_pop    = apb_access & ~i_pwrite & (i_paddr == ADDR_RES) & ~res_empty;

  // Weight registers, writable only while idle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      w00_q <= '0;
      w01_q <= '0;
      w10_q <= '0;
      w11_q <= '0;
    end else if (wr_en) begin
      case (i_paddr)
        ADDR_W00: w00_q <= i_pwdata;
        ADDR_W01: w01_q <= i_pwdata;
        ADDR_W10: w10_q <= i_pwdata;
        ADDR_W11: w11_q <= i_pwdata;
        default:  ;
      endcase
    end
  end

  // Read data mux; zero whenever no read is addressed
  always_comb begin
    o_prdata = '0;
    if (i_psel && !i_pwrite) begin
      if (i_paddr == ADDR_RES)
        o_prdata = res_empty ? '0 : res_rdata;
      else if (i_paddr == ADDR_STAT)
        o_prdata = {26'b0, o_empty, o_full};
    end
  end

  // ---------------- FIFOs ----------------
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(in1_en), .pop_i(pop_in),
    .wdata_i(in1), .rdata_o(f0_rdata), .full_o(f0_full), .empty_o(f0_empty),
    .count_o(f0_cnt)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(in2_en), .pop_i(pop_in),
    .wdata_i(in2), .rdata_o(f1_rdata), .full_o(f1_full), .empty_o(f1_empty),
    .count_o(f1_cnt)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo_res (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(v1_q), .pop_i(res_pop),
    .wdata_i(res_wdata), .rdata_o(res_rdata), .full_o(res_full), .empty_o(res_empty),
    .count_o(res_cnt)
  );

  // ---------------- FSM ----------------
  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: RUN ends once an input queue is dry and stage 1 is empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if ((f0_empty || f1_empty) && !v1_q) state_d = S_DONE;
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: issue a pop only if the result FIFO can absorb the in-flight entry too
  always_comb begin
    done   = (state_q == S_DONE) && start;
    pop_in = (state_q == S_RUN) && !f0_empty && !f1_empty &&
             ((res_cnt + CNT_W'(v1_q)) < CNT_W'(DEPTH));
  end

  // ---------------- Datapath ----------------
  // Stage 1 next: products of the FIFO heads against the stationary weights
  always_comb begin
    v1_d   = pop_in;
    prod_d = prod_q;
    if (pop_in) begin
      prod_d = '{p00: mul_trunc(f0_rdata, w00_q),
                 p10: mul_trunc(f1_rdata, w10_q),
                 p01: mul_trunc(f0_rdata, w01_q),
                 p11: mul_trunc(f1_rdata, w11_q)};
    end
  end

  // Stage 1 register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      v1_q   <= v1_d;
      prod_q <= prod_d;
    end
  end

  // Stage 2: lane sums wrap mod 2^RES_W, which matches the truncated signed
  // sum as well, so one adder serves both builds.
  assign y1        = prod_q.p00 + prod_q.p10;
  assign y2        = prod_q.p01 + prod_q.p11;
  assign res_wdata = {y2, y1};

endmodule

// File: tb/tb_tpu_mm2x2.sv
// Self-checking bench for tpu_mm2x2: table-driven runs, hand-written corner
// sequences (empty start, overflow, leftovers, weight write in RUN, reset
// mid-run) and randomized runs against a plain-arithmetic reference model.
module tb_tpu_mm2x2;
  import tpu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        in1_en = 1'b0;
  logic        in2_en = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [2:0]  o_full;
  logic [2:0]  o_empty;
  logic [31:0] i_paddr = '0;
  logic        i_psel = 1'b0;
  logic        i_pwrite = 1'b0;
  logic [31:0] i_pwdata = '0;
  logic        i_penable = 1'b0;
  logic [31:0] o_prdata;

  int n_checks = 0;
  int n_fail   = 0;

  tpu_mm2x2 dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .in1(in1), .in2(in2), .in1_en(in1_en), .in2_en(in2_en),
    .start(start), .done(done), .o_full(o_full), .o_empty(o_empty),
    .i_paddr(i_paddr), .i_psel(i_psel), .i_pwrite(i_pwrite),
    .i_pwdata(i_pwdata), .i_penable(i_penable), .o_prdata(o_prdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: y = W^T-style 2x2 product, lanes truncated to 16 bits. The low
  // 16 bits of a product do not depend on operand signedness, so this holds
  // for both builds.
  function automatic logic [31:0] ref_mm(input logic [31:0] w00, w01, w10, w11, a, b);
    longint unsigned y1, y2;
    y1 = 64'(a) * 64'(w00) + 64'(b) * 64'(w10);
    y2 = 64'(a) * 64'(w01) + 64'(b) * 64'(w11);
    return {y2[15:0], y1[15:0]};
  endfunction

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge i_clk);
    i_psel = 1'b1; i_pwrite = 1'b1; i_paddr = addr; i_pwdata = data; i_penable = 1'b0;
    @(negedge i_clk);
    i_penable = 1'b1;
    @(negedge i_clk);
    i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge i_clk);
    i_psel = 1'b1; i_pwrite = 1'b0; i_paddr = addr; i_penable = 1'b0;
    @(negedge i_clk);
    i_penable = 1'b1;
    #1 data = o_prdata;
    @(negedge i_clk);
    i_psel = 1'b0; i_penable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    apb_read(addr, rd);
    check(name, rd, exp);
  endtask

  task automatic write_w(input logic [31:0] w00, w01, w10, w11);
    apb_write(ADDR_W00, w00);
    apb_write(ADDR_W01, w01);
    apb_write(ADDR_W10, w10);
    apb_write(ADDR_W11, w11);
  endtask

  task automatic push(input logic e0, input logic e1, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    in1 = a; in2 = b; in1_en = e0; in2_en = e1;
    @(negedge i_clk);
    in1_en = 1'b0; in2_en = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_done"}, done, 1);
  endtask

  task automatic finish_run(input string name);
    @(negedge i_clk);
    start = 1'b0;
    #1 check({name, "_done_drop"}, done, 0);
  endtask

  task automatic run_to_done(input string name);
    @(negedge i_clk);
    start = 1'b1;
    wait_done(name);
    finish_run(name);
  endtask

  typedef struct {
    logic [31:0] w00, w01, w10, w11;
    logic [31:0] a, b;
    logic [31:0] exp;
    bit          last;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] exp_q[$];

  initial begin
    logic [31:0] w0, w1, w2, w3, a, b, e;
    int          k, n;
    bit          new_grp;

    // ---------- reset state ----------
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("rst_done", done, 0);
    check("rst_empty", o_empty, 3'b111);
    check("rst_full", o_full, 3'b000);
    check("rst_prdata_idle", o_prdata, 0);
    read_check("rst_status", ADDR_STAT, 32'h0000_0038);
    read_check("rst_res_read", ADDR_RES, 0);

    // ---------- table-driven runs ----------
    tbl.push_back('{32'd1, 32'd2, 32'd3, 32'd4, 32'd1, 32'd2, 32'h000A_0007, 1'b0});
    tbl.push_back('{32'd1, 32'd2, 32'd3, 32'd4, 32'd3, 32'd4, 32'h0016_000F, 1'b0});
    tbl.push_back('{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'h0022_0017, 1'b0});
    tbl.push_back('{32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd8, 32'h002E_001F, 1'b1});
    tbl.push_back('{32'd1, 32'd2, 32'd2, 32'd3, 32'd9, 32'd10, 32'h0030_001D, 1'b0});
    tbl.push_back('{32'd1, 32'd2, 32'd2, 32'd3, 32'd11, 32'd12, 32'h003A_0023, 1'b1});
    // lane truncation: 5*0xFFFF + 3*2 wraps to 1, 5 + 3*0x8000 = 0x8005
    tbl.push_back('{32'h0001_0001, 32'h0000_FFFF, 32'h0000_8000, 32'd2,
                    32'h0003_0005, 32'd3, 32'h0001_8005, 1'b1});

    new_grp = 1'b1;
    foreach (tbl[i]) begin
      if (new_grp) write_w(tbl[i].w00, tbl[i].w01, tbl[i].w10, tbl[i].w11);
      new_grp = 1'b0;
      push(1'b1, 1'b1, tbl[i].a, tbl[i].b);
      exp_q.push_back(tbl[i].exp);
      if (tbl[i].last) begin
        run_to_done($sformatf("tbl%0d", i));
        n = 0;
        while (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          read_check($sformatf("tbl%0d_res%0d", i, n), ADDR_RES, e);
          n++;
        end
        read_check($sformatf("tbl%0d_extra0", i), ADDR_RES, 0);
        read_check($sformatf("tbl%0d_extra1", i), ADDR_RES, 0);
        check($sformatf("tbl%0d_res_empty", i), o_empty[2], 1);
        new_grp = 1'b1;
      end
    end

    // ---------- start with empty FIFOs ----------
    @(negedge i_clk);
    start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 3) begin
      @(negedge i_clk);
      n++;
    end
    check("empty_start_done", done, 1);
    finish_run("empty_start");
    for (int i = 0; i < 4; i++) read_check($sformatf("empty_read%0d", i), ADDR_RES, 0);

    // ---------- overflow of FIFO0 ----------
    write_w(32'd1, 32'd0, 32'd0, 32'd1);
    for (int i = 1; i <= 4; i++) push(1'b1, 1'b0, 32'(i), 32'd0);
    check("ovf_full_after4", o_full[0], 1);
    push(1'b1, 1'b0, 32'd5, 32'd0);
    check("ovf_full_after5", o_full[0], 1);
    read_check("ovf_status", ADDR_STAT, 32'h0000_0031);
    for (int i = 1; i <= 4; i++) push(1'b0, 1'b1, 32'd0, 32'(10 * i));
    check("ovf_full_both", o_full, 3'b011);
    run_to_done("ovf");
    for (int i = 1; i <= 4; i++)
      read_check($sformatf("ovf_res%0d", i), ADDR_RES, {16'(10 * i), 16'(i)});
    check("ovf_fifth_dropped", o_empty[0], 1);

    // ---------- unequal occupancy leaves entries queued ----------
    push(1'b1, 1'b1, 32'd7, 32'd9);
    push(1'b1, 1'b0, 32'd8, 32'd0);
    run_to_done("left1");
    read_check("left1_res", ADDR_RES, 32'h0009_0007);
    check("left1_fifo0_kept", o_empty[0], 0);
    push(1'b0, 1'b1, 32'd0, 32'd11);
    run_to_done("left2");
    read_check("left2_res", ADDR_RES, 32'h000B_0008);

    // ---------- weight write during RUN is ignored ----------
    write_w(32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 32'(2 * i + 1), 32'(2 * i + 2));
    run_to_done("wrun_fill");
    push(1'b1, 1'b1, 32'd1, 32'd1);
    @(negedge i_clk);
    start = 1'b1;
    repeat (4) @(negedge i_clk);
    check("wrun_stalled", done, 0);
    check("wrun_res_full", o_full[2], 1);
    apb_write(ADDR_W00, 32'd100);
    apb_write(ADDR_W11, 32'd50);
    read_check("wrun_res0", ADDR_RES, 32'h000A_0007);
    read_check("wrun_res1", ADDR_RES, 32'h0016_000F);
    read_check("wrun_res2", ADDR_RES, 32'h0022_0017);
    read_check("wrun_res3", ADDR_RES, 32'h002E_001F);
    wait_done("wrun");
    finish_run("wrun");
    read_check("wrun_old_weights", ADDR_RES, ref_mm(1, 2, 3, 4, 1, 1));

    // ---------- randomized runs against the reference model ----------
    for (int r = 0; r < 6; r++) begin
      w0 = $urandom; w1 = $urandom; w2 = $urandom; w3 = $urandom;
      write_w(w0, w1, w2, w3);
      k = $urandom_range(0, 4);
      for (int j = 0; j < k; j++) begin
        a = $urandom; b = $urandom;
        push(1'b1, 1'b1, a, b);
        exp_q.push_back(ref_mm(w0, w1, w2, w3, a, b));
      end
      run_to_done($sformatf("rnd%0d", r));
      n = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        read_check($sformatf("rnd%0d_res%0d", r, n), ADDR_RES, e);
        n++;
      end
      read_check($sformatf("rnd%0d_drained", r), ADDR_RES, 0);
    end

    // ---------- reset in the middle of a run ----------
    write_w(32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 32'(i + 1), 32'(i + 2));
    run_to_done("mrst_fill");
    push(1'b1, 1'b1, 32'd3, 32'd3);
    @(negedge i_clk);
    start = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    start = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check("mrst_done", done, 0);
    check("mrst_empty", o_empty, 3'b111);
    check("mrst_full", o_full, 3'b000);
    read_check("mrst_res_read", ADDR_RES, 0);
    read_check("mrst_status", ADDR_STAT, 32'h0000_0038);
    push(1'b1, 1'b1, 32'd5, 32'd6);
    run_to_done("mrst_zero_w");
    check("mrst_result_present", o_empty[2], 0);
    read_check("mrst_weights_cleared", ADDR_RES, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_mm2x2.md
Name: tpu_mm2x2

Overview:
- Toy 2x2 weight-stationary matrix-vector engine.
- Weights are loaded through an APB slave port. Input vectors (in1,in2) are pushed into two input FIFOs.
- On start, each vector is multiplied by the 2x2 weight matrix and the packed result is written to a result FIFO.
- The result FIFO is drained by APB reads. The block sits as a slave behind the system APB master.

Parameters:
- DATA_W, 32, width of in1/in2, weights and APB data.
- DEPTH, 4, entries per FIFO (power of two).
- RES_W, 16, width of each packed result lane.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; the block has one clock, and reset is synchronous and active-high
- in1  in  DATA_W  vector element 0
- in2  in  DATA_W  vector element 1
- in1_en  in  1  push in1 into FIFO0
- in2_en  in  1  push in2 into FIFO1
- start  in  1  level request to process the queued vectors
- done  out  1  processing complete (level)
- o_full  out  3  full flags: [0] FIFO0, [1] FIFO1, [2] result FIFO
- o_empty  out  3  empty flags, same bit order
- i_paddr  in  32  APB address
- i_psel  in  1  APB select
- i_pwrite  in  1  APB write
- i_pwdata  in  32  APB write data
- i_penable  in  1  APB enable
- o_prdata  out  32  APB read data

Behaviour:
- Reset: all FIFOs are empty (o_empty=3'b111, o_full=0), weights=0, done=0, o_prdata=0, FSM=IDLE.
- Reset mid-operation aborts the run and discards all data.
- APB interface: no wait states; a transfer completes in its access phase (i_psel & i_penable).
- APB write, address 0/1/2/3 -> W00/W01/W10/W11.
  - Writes are accepted only in IDLE and ignored otherwise.
  - Writes to other addresses are ignored.
- APB read:
  - o_prdata is combinational while i_psel & !i_pwrite; it is 0 otherwise.
  - Address 0 returns the result FIFO head, which pops in the access phase. Reading while empty returns 0 and does not pop.
  - Address 4 returns {26'b0, o_empty, o_full}. Other addresses return 0.
- Input push: an en pulse pushes into its FIFO on the clock edge. A push to a full FIFO is dropped. Pushes are allowed in any state.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1.
  - RUN: each cycle that FIFO0 and FIFO1 are both non-empty and the result FIFO has space (counting in-flight entries), pop one element from each.
    - Stage 1 registers the four products.
    - Stage 2 sums them and pushes the result. Latency from pop to result visible = 2 cycles.
  - RUN -> DONE when either input FIFO is empty and the pipeline is drained.
  - DONE: done=1 while start=1. DONE -> IDLE when start=0, and done drops in the same cycle.
  - Start with empty input FIFOs: RUN -> DONE after at most 2 cycles, no results produced.
- Arithmetic, unsigned, for each vector:
  - y1 = in1*W00 + in2*W10
  - y2 = in1*W01 + in2*W11
  - Both are truncated mod 2^RES_W.
  - Result word = {y2[15:0], y1[15:0]}.
- Unequal FIFO occupancies: leftover entries remain queued for the next run.

Optional Feature:
- SIGNED_MAC_EN defined: operands are two's-complement, and products and sums are signed before truncation.
- Undefined: everything is unsigned.

Decomposition:
- Package tpu_pkg holds:
  - DATA_W, RES_W, DEPTH
  - APB address constants ADDR_W00=0, ADDR_W01=1, ADDR_W10=2, ADDR_W11=3, ADDR_RES=0, ADDR_STAT=4
  - FSM state enum
- Sub-module sync_fifo (DATA_W wide, DEPTH deep, push/pop/full/empty), instantiated three times.

Test Plan:
- Run 1:
  - Setup: write W=1,2,3,4, push pairs (1,2),(3,4),(5,6),(7,8), then start.
  - Expected: done rises; start=0 clears it; four address-0 reads return 0x000A0007, 0x0016000F, 0x00220017, 0x002E001F.
- Run 2:
  - Setup: write W=1,2,2,3, push (9,10),(11,12), then start.
  - Expected: reads return 0x0030001D, 0x003A0023, then 0, 0 with o_empty[2]=1.
- Empty start: start with all FIFOs empty -> done within 3 cycles; four reads return 0.
- Overflow: five pushes to FIFO0 -> o_full[0]=1 after the fourth push; the fifth is dropped; the address-4 status read reflects this.
- Weight write during RUN is ignored: results still use the old W.
- Reset mid-RUN: assert i_rst -> done=0, o_empty=3'b111, and address-0 reads return 0.
